// File: rtl/epu_out_packer.sv
// epu_out_packer: packs an 8-bit result stream little-endian into 32-bit
// words and writes them to consecutive SRAM word addresses on the EPU port.
// It pulses end_signal after the final write of a job.
//
// Handshake: a byte transfers on a rising CLK edge where res_valid and
// res_ready are both high. res_ready is high in RUN only and never depends
// on res_valid. There is no back-pressure inside RUN. The producer may hold
// res_valid low for any number of cycles without losing state.
module epu_out_packer #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 15
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start_signal,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              res_valid,
  input  logic [7:0]        res_data,
  output logic              res_ready,
  output logic [ADDR_W-1:0] A_epu,
  output logic [3:0]        WEB_epu,
  output logic [31:0]       DI_epu,
  output logic              end_signal,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [3:0]        web_q, web_d;
  logic [31:0]       di_q, di_d;
  logic [31:0]       word;

  // State and port registers; reset forces the SRAM port idle immediately
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      lane_q   <= '0;
      pack_q   <= '0;
      a_q      <= '0;
      web_q    <= 4'b1111;
      di_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      a_q      <= a_d;
      web_q    <= web_d;
      di_q     <= di_d;
    end
  end

  // Next-state and datapath; WEB defaults to idle so a write lasts one cycle
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    a_d      = a_q;
    web_d    = 4'b1111;
    di_d     = di_q;
    // Current word with the incoming byte merged into its lane.
    word                      = pack_q;
    word[{lane_q, 3'b000} +: 8] = res_data;

    case (state_q)
      IDLE: begin
        if (start_signal) begin
          addr_d   = cfg_base;
          remain_d = cfg_len;
          lane_d   = 2'd0;
          pack_d   = '0;
          state_d  = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (res_valid) begin
          remain_d = remain_q - LEN_W'(1);
          if (lane_q == 2'd3 || remain_q == LEN_W'(1)) begin
            // Word complete or job ends. Write the whole word; unfilled lanes stay zero.
            a_d    = addr_q;
            web_d  = 4'b0000;
            di_d   = word;
            addr_d = addr_q + ADDR_W'(1);
            lane_d = 2'd0;
            pack_d = '0;
          end else begin
            lane_d = lane_q + 2'd1;
            pack_d = word;
          end
          if (remain_q == LEN_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign res_ready  = (state_q == RUN);
  assign end_signal = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign A_epu      = a_q;
  assign WEB_epu    = web_q;
  assign DI_epu     = di_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_epu_out_packer.sv
// Directed testbench for epu_out_packer. A negedge monitor logs every SRAM
// write and end_signal pulse with the edge index. Each test task compares
// the logged events against hand-computed addresses, data words and cycles.
module tb_epu_out_packer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start_signal = 1'b0;
  logic [11:0] cfg_base = '0;
  logic [14:0] cfg_len = '0;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = '0;
  logic        res_ready;
  logic [11:0] A_epu;
  logic [3:0]  WEB_epu;
  logic [31:0] DI_epu;
  logic        end_signal;
  logic        busy;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int bad_web = 0;

  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          end_q[$];

  epu_out_packer #(.ADDR_W(12), .LEN_W(15)) dut (
    .CLK(CLK), .RSTn(RSTn), .start_signal(start_signal),
    .cfg_base(cfg_base), .cfg_len(cfg_len),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .A_epu(A_epu), .WEB_epu(WEB_epu), .DI_epu(DI_epu),
    .end_signal(end_signal), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / edge counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: at a negedge with cyc==k the value shown is the cycle after edge k
  always @(negedge CLK) begin
    if (WEB_epu == 4'b0000) begin
      wa_q.push_back(A_epu);
      wd_q.push_back(DI_epu);
      wc_q.push_back(cyc);
    end else if (WEB_epu != 4'b1111) begin
      bad_web <= bad_web + 1;
    end
    if (end_signal) end_q.push_back(cyc);
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Start pulse; returns the edge index at which it was accepted.
  task automatic do_start(input logic [11:0] base, input logic [14:0] len, output int e);
    start_signal = 1'b1; cfg_base = base; cfg_len = len;
    @(negedge CLK);
    e = cyc;
    start_signal = 1'b0; cfg_base = 12'hABC; cfg_len = 15'd3;
  endtask

  // One byte presented for a cycle; returns acceptance edge.
  task automatic send_byte(input logic [7:0] d, output int k);
    res_valid = 1'b1; res_data = d;
    @(negedge CLK);
    k = cyc;
    res_valid = 1'b0; res_data = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++; if (res_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b need 0", res_ready); end
    vectors++; if (A_epu !== 12'h000) begin miscompares++; $display("FAIL reset_addr got %h need 000", A_epu); end
    vectors++; if (WEB_epu !== 4'b1111) begin miscompares++; $display("FAIL reset_web got %b need 1111", WEB_epu); end
    vectors++; if (DI_epu !== 32'h0) begin miscompares++; $display("FAIL reset_di got %h need 0", DI_epu); end
    vectors++; if (end_signal !== 1'b0) begin miscompares++; $display("FAIL reset_end got %b need 0", end_signal); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b need 0", busy); end
  endtask

  task automatic test_full_words();
    int e; int k[8]; int w0; int n0;
    w0 = wa_q.size(); n0 = end_q.size();
    do_start(12'h010, 15'd8, e);
    vectors++; if (res_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_start got %b need 1", res_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL full_busy got %b need 1", busy); end
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), k[i]);
    vectors++; if (k[0] !== e + 1) begin miscompares++; $display("FAIL full_first_accept got %0d need %0d", k[0], e + 1); end
    idle_cycles(2);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_after got %b need 0", busy); end
    idle_cycles(2);
    vectors++; if (wa_q.size() - w0 !== 2) begin miscompares++; $display("FAIL full_write_count got %0d need 2", wa_q.size() - w0); end
    vectors++; if (wa_q[w0] !== 12'h010 || wd_q[w0] !== 32'h04030201) begin miscompares++; $display("FAIL full_word0 got [%h]=%h need [010]=04030201", wa_q[w0], wd_q[w0]); end
    vectors++; if (wa_q[w0+1] !== 12'h011 || wd_q[w0+1] !== 32'h08070605) begin miscompares++; $display("FAIL full_word1 got [%h]=%h need [011]=08070605", wa_q[w0+1], wd_q[w0+1]); end
    vectors++; if (wc_q[w0] !== k[3]) begin miscompares++; $display("FAIL full_word0_cycle got %0d need %0d", wc_q[w0], k[3]); end
    vectors++; if (wc_q[w0+1] - wc_q[w0] !== 4) begin miscompares++; $display("FAIL full_write_spacing got %0d need 4", wc_q[w0+1] - wc_q[w0]); end
    vectors++; if (end_q.size() - n0 !== 1) begin miscompares++; $display("FAIL full_end_count got %0d need 1", end_q.size() - n0); end
    vectors++; if (end_q[n0] !== k[7] + 1) begin miscompares++; $display("FAIL full_end_cycle got %0d need %0d", end_q[n0], k[7] + 1); end
  endtask

  task automatic test_partial();
    int e; int k; int w0;
    logic [7:0] b[5];
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    w0 = wa_q.size();
    do_start(12'h020, 15'd5, e);
    for (int i = 0; i < 5; i++) send_byte(b[i], k);
    idle_cycles(4);
    vectors++; if (wa_q.size() - w0 !== 2) begin miscompares++; $display("FAIL part_write_count got %0d need 2", wa_q.size() - w0); end
    vectors++; if (wa_q[w0] !== 12'h020 || wd_q[w0] !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL part_word0 got [%h]=%h need [020]=ddccbbaa", wa_q[w0], wd_q[w0]); end
    vectors++; if (wa_q[w0+1] !== 12'h021 || wd_q[w0+1] !== 32'h000000EE) begin miscompares++; $display("FAIL part_word1 got [%h]=%h need [021]=000000ee", wa_q[w0+1], wd_q[w0+1]); end
    vectors++; if (wc_q[w0+1] !== k) begin miscompares++; $display("FAIL part_last_cycle got %0d need %0d", wc_q[w0+1], k); end
    vectors++; if (bad_web !== 0) begin miscompares++; $display("FAIL part_web_legal got %0d illegal need 0", bad_web); end
  endtask

  task automatic test_wrap();
    int e; int k; int w0;
    w0 = wa_q.size();
    do_start(12'hFFF, 15'd8, e);
    for (int i = 0; i < 8; i++) send_byte(8'((i + 1) * 8'h11), k);
    idle_cycles(4);
    vectors++; if (wa_q.size() - w0 !== 2) begin miscompares++; $display("FAIL wrap_write_count got %0d need 2", wa_q.size() - w0); end
    vectors++; if (wa_q[w0] !== 12'hFFF || wd_q[w0] !== 32'h44332211) begin miscompares++; $display("FAIL wrap_word0 got [%h]=%h need [fff]=44332211", wa_q[w0], wd_q[w0]); end
    vectors++; if (wa_q[w0+1] !== 12'h000 || wd_q[w0+1] !== 32'h88776655) begin miscompares++; $display("FAIL wrap_word1 got [%h]=%h need [000]=88776655", wa_q[w0+1], wd_q[w0+1]); end
  endtask

  task automatic test_gaps_and_restart();
    int e; int k; int w0; int n0; int e2;
    w0 = wa_q.size(); n0 = end_q.size();
    do_start(12'h100, 15'd4, e);
    send_byte(8'h10, k); idle_cycles(2);
    send_byte(8'h20, k);
    // Second start mid-job with a different config must be ignored.
    do_start(12'h200, 15'd1, e2);
    idle_cycles(1);
    vectors++; if (wa_q.size() - w0 !== 0) begin miscompares++; $display("FAIL gap_no_early_write got %0d need 0", wa_q.size() - w0); end
    vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL gap_state_hold got %0d need 1", dbg_state); end
    send_byte(8'h30, k); idle_cycles(2);
    send_byte(8'h40, k);
    idle_cycles(6);
    vectors++; if (wa_q.size() - w0 !== 1) begin miscompares++; $display("FAIL gap_write_count got %0d need 1", wa_q.size() - w0); end
    vectors++; if (wa_q[w0] !== 12'h100 || wd_q[w0] !== 32'h40302010) begin miscompares++; $display("FAIL gap_word got [%h]=%h need [100]=40302010", wa_q[w0], wd_q[w0]); end
    vectors++; if (wc_q[w0] !== k) begin miscompares++; $display("FAIL gap_write_cycle got %0d need %0d", wc_q[w0], k); end
    vectors++; if (end_q.size() - n0 !== 1) begin miscompares++; $display("FAIL gap_end_count got %0d need 1", end_q.size() - n0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gap_busy_after got %b need 0", busy); end
  endtask

  task automatic test_zero_len();
    int e; int w0; int n0;
    w0 = wa_q.size(); n0 = end_q.size();
    do_start(12'h040, 15'd0, e);
    vectors++; if (res_ready !== 1'b0) begin miscompares++; $display("FAIL zero_ready got %b need 0", res_ready); end
    idle_cycles(4);
    vectors++; if (end_q.size() - n0 !== 1) begin miscompares++; $display("FAIL zero_end_count got %0d need 1", end_q.size() - n0); end
    vectors++; if (end_q[n0] !== e) begin miscompares++; $display("FAIL zero_end_cycle got %0d need %0d", end_q[n0], e); end
    vectors++; if (wa_q.size() - w0 !== 0) begin miscompares++; $display("FAIL zero_no_write got %0d need 0", wa_q.size() - w0); end
  endtask

  task automatic test_reset_mid_job();
    int e; int k; int w0; int n0;
    w0 = wa_q.size(); n0 = end_q.size();
    do_start(12'h300, 15'd8, e);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), k);
    RSTn = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || res_ready !== 1'b0 || end_signal !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ctrl got busy=%b ready=%b end=%b need 0 0 0", busy, res_ready, end_signal); end
    vectors++; if (WEB_epu !== 4'b1111 || A_epu !== 12'h000 || DI_epu !== 32'h0) begin miscompares++; $display("FAIL rst_mid_port got web=%b a=%h di=%h need 1111 000 0", WEB_epu, A_epu, DI_epu); end
    idle_cycles(2);
    RSTn = 1'b1;
    idle_cycles(6);
    vectors++; if (wa_q.size() - w0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_write got %0d need 0", wa_q.size() - w0); end
    vectors++; if (end_q.size() - n0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_end got %0d need 0", end_q.size() - n0); end
  endtask

  task automatic test_back_to_back();
    int e; int k; int w0; int n0;
    w0 = wa_q.size(); n0 = end_q.size();
    do_start(12'h050, 15'd4, e);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), k);
    idle_cycles(2);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_after_done got %b need 0", busy); end
    do_start(12'h060, 15'd1, e);
    vectors++; if (e !== k + 3) begin miscompares++; $display("FAIL b2b_start_edge got %0d need %0d", e, k + 3); end
    send_byte(8'h5A, k);
    idle_cycles(4);
    vectors++; if (wa_q.size() - w0 !== 2) begin miscompares++; $display("FAIL b2b_write_count got %0d need 2", wa_q.size() - w0); end
    vectors++; if (wa_q[w0] !== 12'h050 || wd_q[w0] !== 32'h04030201) begin miscompares++; $display("FAIL b2b_word0 got [%h]=%h need [050]=04030201", wa_q[w0], wd_q[w0]); end
    vectors++; if (wa_q[w0+1] !== 12'h060 || wd_q[w0+1] !== 32'h0000005A) begin miscompares++; $display("FAIL b2b_word1 got [%h]=%h need [060]=0000005a", wa_q[w0+1], wd_q[w0+1]); end
    vectors++; if (end_q.size() - n0 !== 2) begin miscompares++; $display("FAIL b2b_end_count got %0d need 2", end_q.size() - n0); end
  endtask

  // Sequence
  initial begin
    idle_cycles(3);
    test_reset();
    RSTn = 1'b1;
    idle_cycles(2);
    test_full_words();
    test_partial();
    test_wrap();
    test_gaps_and_restart();
    test_zero_len();
    test_reset_mid_job();
    test_back_to_back();
    idle_cycles(2);
    vectors++; if (bad_web !== 0) begin miscompares++; $display("FAIL web_legal_overall got %0d illegal need 0", bad_web); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/epu_out_packer.md
# epu_out_packer

Byte-to-word packer and write sequencer that sits directly upstream of the EPU port of the output SRAM wrapper. It accepts the EPU's 8-bit result stream and packs it little-endian into 32-bit words. It writes those words to consecutive SRAM word addresses through the wrapper's `A_epu`/`WEB_epu`/`DI_epu` port. After the last write of a job it pulses `end_signal`, which hands SRAM ownership to the AXI side.

## Interface
Parameters:
- `ADDR_W`, 12: SRAM word-address width; must match the wrapper's `A_epu`.
- `LEN_W`, 15: job byte-count width; covers 1..16384 bytes (4096 words).

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock.
- `RSTn` in 1: asynchronous active-low reset.
- `start_signal` in 1: one-cycle job start; also drives the wrapper's `start_signal`.
- `cfg_base` in ADDR_W: first word address; sampled when `start_signal` is accepted.
- `cfg_len` in LEN_W: job length in bytes; sampled when `start_signal` is accepted; 0 is legal.
- `res_valid` in 1: result byte valid.
- `res_data` in 8: result byte.
- `res_ready` out 1: byte accepted when `res_valid & res_ready`.
- `A_epu` out ADDR_W: SRAM word address (registered).
- `WEB_epu` out 4: active-low write enable (registered); 4'b0000 = write, 4'b1111 = idle. No other values are ever driven.
- `DI_epu` out 32: write data (registered).
- `end_signal` out 1: one-cycle pulse after the final write of a job.
- `busy` out 1: high in RUN, FLUSH and DONE.

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset state is IDLE.
- IDLE, `start_signal`=1:
  - latch `cfg_base` into `addr`, `cfg_len` into `remain`; clear `lane` (2 bits) and `pack` (32 bits).
  - go to RUN if `cfg_len`≠0, else to DONE.
- IDLE, `start_signal`=0: stay. `start_signal` in any other state is ignored.
- RUN:
  - `res_ready`=1 in RUN only; 0 in every other state.
  - Each accepted byte is placed at `pack[8*lane +: 8]`; `lane` increments; `remain` decrements.
  - A write is issued when the accepted byte is in lane 3, or when it is the last byte (`remain`==1). The write loads `DI_epu` with the completed word (partial word: unfilled lanes are 0), loads `A_epu`=`addr`, sets `WEB_epu`=0; then `addr` increments, and `lane` and `pack` clear.
  - Accepting the last byte moves to FLUSH.
- FLUSH: one cycle, during which the final write is on the port. Go to DONE.
- DONE: `end_signal`=1 for one cycle. Go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 4095+1 wraps to 0.
- The wrapper enables a write only when all four WEB bits are 0. Partial words are therefore always written as full words with zero padding.

## Timing
- Reset values: `res_ready`=0, `A_epu`=0, `WEB_epu`=4'b1111, `DI_epu`=0, `end_signal`=0, `busy`=0.
- Start accepted at edge e: RUN from cycle e+1; `res_ready`=1 in that same cycle.
- Byte completing a word accepted at edge k: write (`WEB_epu`=0) is on the port in cycle k+1 only. `WEB_epu` returns to 4'b1111 in cycle k+2 unless another word completes.
- Full throughput: one byte per cycle, one write per 4 cycles. No back-pressure in RUN.
- Last byte accepted at edge k: final write in cycle k+1 (FLUSH); `end_signal` in cycle k+2 (DONE); IDLE from k+3. The final write therefore lands while the wrapper is still in EPU state.
- `cfg_len`=0: `end_signal` in cycle e+1; no write is issued.
- `res_valid` gaps: state and `lane` hold; no write is issued.
- Reset mid-job: immediate return to IDLE with reset output values. No `end_signal` and no further writes; partial data is discarded.
- Back-to-back jobs: `start_signal` is accepted in the cycle after DONE at the earliest.

## Test plan
- Reset, then `cfg_base`=0x010, `cfg_len`=8; bytes 0x01..0x08 on consecutive cycles -> writes [0x010]=0x04030201 and [0x011]=0x08070605 four cycles apart; one `end_signal` pulse two cycles after byte 0x08 is accepted; `busy` low afterwards.
- `cfg_len`=5, bytes 0xAA,0xBB,0xCC,0xDD,0xEE -> [base]=0xDDCCBBAA, [base+1]=0x000000EE; `WEB_epu` only 4'b0000 or 4'b1111 throughout.
- `cfg_base`=0xFFF, `cfg_len`=8 -> writes at 0xFFF then 0x000 (wrap).
- `res_valid` toggling 1,0,0,1,... over 4 bytes -> exactly one write, issued the cycle after the 4th accepted byte. A second `start_signal` pulsed mid-job is ignored (single `end_signal`, no re-latched config).
- `cfg_len`=0 -> `end_signal` one cycle after start, no write. Mid-job `RSTn` low after 3 of 8 bytes -> all outputs at reset values, no `end_signal`, no write of the partial word.
